// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM states, instruction field positions
// and PC offsets. The control unit slices instructions with the same constants.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam int unsigned COND_MSB  = 31;
  localparam int unsigned COND_LSB  = 28;
  localparam int unsigned OP_MSB    = 27;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_MSB = 25;
  localparam int unsigned FUNCT_LSB = 20;
  localparam int unsigned RN_MSB    = 19;
  localparam int unsigned RN_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 12;
  localparam int unsigned RM_MSB    = 3;
  localparam int unsigned RM_LSB    = 0;
  localparam int unsigned IMM24_MSB = 23;
  localparam int unsigned IMM24_LSB = 0;

  localparam int unsigned PC_STEP        = 4;
  localparam int unsigned PC_READ_OFFSET = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of a 32-bit instruction word into the fields the
// control unit decodes.
module instr_field_split
  import fetch_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  cond,
  output logic [1:0]  op,
  output logic [5:0]  funct,
  output logic [3:0]  rn,
  output logic [3:0]  rd,
  output logic [3:0]  rm,
  output logic [23:0] imm24
);

  assign cond  = instr[COND_MSB:COND_LSB];
  assign op    = instr[OP_MSB:OP_LSB];
  assign funct = instr[FUNCT_MSB:FUNCT_LSB];
  assign rn    = instr[RN_MSB:RN_LSB];
  assign rd    = instr[RD_MSB:RD_LSB];
  assign rm    = instr[RM_MSB:RM_LSB];
  assign imm24 = instr[IMM24_MSB:IMM24_LSB];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, request/ready handshake with
// instruction memory, instruction latch and branch redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus8,
  output logic [3:0]        cond,
  output logic [1:0]        op,
  output logic [5:0]        funct,
  output logic [3:0]        rn,
  output logic [3:0]        rd,
  output logic [3:0]        rm,
  output logic [23:0]       imm24
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] pc_out_nxt;
  logic [31:0]       instr_nxt;

  // Redirect targets are word aligned; the low target bits are dropped.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target[1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next data-register values
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    pc_out_nxt = pc_out;
    instr_nxt  = instr;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_ready) begin
          instr_nxt  = imem_rdata;
          pc_out_nxt = pc;
          state_nxt  = VALID;
        end
      end
      VALID: begin
        if (!stall) begin
          pc_nxt    = pc_src ? {branch_target[ADDR_W-1:2], 2'b00}
                             : pc + ADDR_W'(PC_STEP);
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data registers; handshake outputs are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      pc_out      <= RESET_PC;
      pc_plus8    <= RESET_PC + ADDR_W'(PC_READ_OFFSET);
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      pc_out      <= pc_out_nxt;
      pc_plus8    <= pc_out_nxt + ADDR_W'(PC_READ_OFFSET);
      instr       <= instr_nxt;
      imem_req    <= (state_nxt == REQ);
      instr_valid <= (state_nxt == VALID);
    end
  end

  assign imem_addr = pc;

  instr_field_split u_split (
    .instr (instr),
    .cond  (cond),
    .op    (op),
    .funct (funct),
    .rn    (rn),
    .rd    (rd),
    .rm    (rm),
    .imm24 (imm24)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, with a queue-based scoreboard fed by a PC-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] FIXED_WORD = 32'hE281_0004;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus8;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rn;
  logic [3:0]  rd;
  logic [3:0]  rm;
  logic [23:0] imm24;

  int total = 0;
  int bad   = 0;
  logic fixed_word = 1'b1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_t;
  fetch_t exp_q[$];
  logic [31:0] exp_pc = RST_PC;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .pc_src(pc_src), .branch_target(branch_target), .instr_valid(instr_valid),
    .instr(instr), .pc_out(pc_out), .pc_plus8(pc_plus8), .cond(cond), .op(op),
    .funct(funct), .rn(rn), .rd(rd), .rm(rm), .imm24(imm24)
  );

  function automatic logic [31:0] scramble(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E37_79B1;
    return h ^ {h[15:0], h[31:16]};
  endfunction

  // Instruction memory contents as a function of address
  assign imem_rdata = fixed_word ? FIXED_WORD : scramble(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: PC follows the branch/sequential rule; every accepted
  // memory response is pushed as an expected instruction.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_pc = RST_PC;
    end else begin
      if (imem_req && imem_ready)
        exp_q.push_back('{pc: exp_pc, word: fixed_word ? FIXED_WORD : scramble(exp_pc)});
      if (instr_valid && !stall)
        exp_pc = pc_src ? (branch_target & ~32'h3) : exp_pc + 32'd4;
    end
  end

  // Monitor: checks request address, pops on each new instruction, and
  // verifies that outputs hold while the same instruction stays valid.
  logic        prev_valid = 1'b0;
  logic [31:0] s_instr, s_pc_out, s_p8, s_addr;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (imem_req) chk("req_addr", imem_addr, exp_pc);
      if (imem_req && instr_valid) chk("req_valid_excl", 32'(imem_req & instr_valid), 32'd0);
      if (instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          fetch_t e;
          e = exp_q.pop_front();
          chk("sb_pc_out", pc_out, e.pc);
          chk("sb_instr", instr, e.word);
          chk("sb_pc_plus8", pc_plus8, e.pc + 32'd8);
          chk("sb_cond", 32'(cond), e.word >> 28);
          chk("sb_op", 32'(op), (e.word >> 26) & 32'h3);
          chk("sb_funct", 32'(funct), (e.word >> 20) & 32'h3F);
          chk("sb_rn", 32'(rn), (e.word >> 16) & 32'hF);
          chk("sb_rd", 32'(rd), (e.word >> 12) & 32'hF);
          chk("sb_rm", 32'(rm), e.word & 32'hF);
          chk("sb_imm24", 32'(imm24), e.word & 32'hFF_FFFF);
        end
      end else if (instr_valid && prev_valid) begin
        chk("hold_instr", instr, s_instr);
        chk("hold_pc_out", pc_out, s_pc_out);
        chk("hold_pc_plus8", pc_plus8, s_p8);
        chk("hold_addr", imem_addr, s_addr);
      end
      prev_valid = instr_valid;
      s_instr = instr;
      s_pc_out = pc_out;
      s_p8 = pc_plus8;
      s_addr = imem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; pc_src = 1'b0; branch_target = '0; imem_ready = 1'b1;
    tick(); tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_pc_out", pc_out, RST_PC);
    chk("rst_instr", instr, 32'd0);

    // Release with memory always ready
    #1 rst_n = 1'b1;
    tick();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    tick();
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_cond", 32'(cond), 32'hE);
    chk("first_op", 32'(op), 32'd0);
    chk("first_funct", 32'(funct), 32'h28);
    chk("first_rn", 32'(rn), 32'd1);
    chk("first_rd", 32'(rd), 32'd0);
    chk("first_rm", 32'(rm), 32'd4);
    chk("first_pc_plus8", pc_plus8, 32'd8);
    imem_ready = 1'b0;
    tick();
    chk("second_addr", imem_addr, 32'd4);

    // Ready withheld for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, 32'd4);
      chk("wait_valid", 32'(instr_valid), 32'd0);
    end
    imem_ready = 1'b1;
    tick();
    chk("late_valid", 32'(instr_valid), 32'd1);
    chk("late_pc_out", pc_out, 32'd4);

    // Stall with pc_src asserted throughout, then redirect
    stall = 1'b1; pc_src = 1'b1; branch_target = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_pc_out", pc_out, 32'd4);
    end
    stall = 1'b0; branch_target = 32'h0000_0103;
    tick();
    chk("redir_addr", imem_addr, 32'h0000_0100);
    pc_src = 1'b0;
    tick();
    chk("redir_pc_out", pc_out, 32'h0000_0100);

    // PC wrap at the top of the address space
    pc_src = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    pc_src = 1'b0; branch_target = '0;
    tick();
    chk("wrap_pc_plus8", pc_plus8, 32'h0000_0004);
    tick();
    chk("wrap_next_addr", imem_addr, 32'd0);

    // Reset asserted mid-request, with a late ready that must be discarded
    imem_ready = 1'b0;
    tick();
    #1 rst_n = 1'b0; imem_ready = 1'b1;
    #1;
    chk("rstreq_req", 32'(imem_req), 32'd0);
    chk("rstreq_valid", 32'(instr_valid), 32'd0);
    tick(); tick();
    chk("rstreq_hold_valid", 32'(instr_valid), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("rstreq_restart", 32'(imem_req), 32'd1);
    tick();
    chk("rstreq_refetch", 32'(instr_valid), 32'd1);

    // Reset asserted mid-valid
    #1 rst_n = 1'b0;
    #1;
    chk("rstval_valid", 32'(instr_valid), 32'd0);
    chk("rstval_req", 32'(imem_req), 32'd0);
    chk("rstval_instr", instr, 32'd0);
    tick();
    #1 rst_n = 1'b1;
    tick();
    chk("rstval_restart_addr", imem_addr, RST_PC);
    fixed_word = 1'b0;

    // Random traffic against the scoreboard
    for (int n = 0; n < 600; n++) begin
      tick();
      if ($urandom_range(0, 149) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rnd_rst_req", 32'(imem_req), 32'd0);
        chk("rnd_rst_valid", 32'(instr_valid), 32'd0);
        tick();
        #1 rst_n = 1'b1;
      end
      imem_ready    = ($urandom_range(0, 9) < 6);
      stall         = ($urandom_range(0, 9) < 3);
      pc_src        = ($urandom_range(0, 9) < 3);
      branch_target = $urandom();
    end

    stall = 1'b0; pc_src = 1'b0; imem_ready = 1'b1;
    for (int n = 0; n < 6; n++) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the control unit. Holds the program counter and runs a request/ready handshake with instruction memory. Latches the returned word and presents it, already split into the fields the control unit decodes (cond, op, funct, Rd, …), together with PC values for the datapath. Consumes the control unit's PCSrc and the branch target to redirect the next fetch.

## Interface
Parameters:
- ADDR_W, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address, always equal to the current PC.
- imem_ready  in  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  downstream cannot accept a new instruction; hold the current one.
- pc_src  in  1  PCSrc from the control unit: take the branch.
- branch_target  in  ADDR_W  redirect address; bits [1:0] are ignored and forced to 0.
- instr_valid  out  1  instr and all field outputs are valid.
- instr  out  32  latched instruction register.
- pc_out  out  ADDR_W  address of the latched instruction.
- pc_plus8  out  ADDR_W  pc_out + 8 (architectural PC read value).
- cond  out  4  instr[31:28].
- op  out  2  instr[27:26].
- funct  out  6  instr[25:20].
- rn  out  4  instr[19:16].
- rd  out  4  instr[15:12].
- rm  out  4  instr[3:0].
- imm24  out  24  instr[23:0].

## Operation
- FSM states:
  - IDLE: reset state. Moves unconditionally to REQ on the next edge.
  - REQ: imem_req=1, imem_addr=pc. On imem_ready: instr<=imem_rdata, pc_out<=pc, go to VALID. Otherwise stay in REQ, holding address and request.
  - VALID: instr_valid=1, imem_req=0.
    - If stall=1: hold everything; pc_src is not sampled.
    - If stall=0 and pc_src=1: pc<={branch_target[ADDR_W-1:2],2'b00}, go to REQ.
    - If stall=0 and pc_src=0: pc<=pc+4, go to REQ.
- pc_src and branch_target are sampled only in VALID with stall=0. They are ignored in IDLE and REQ.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 wraps to 0, and pc_plus8 wraps the same way.
- Field outputs are combinational slices of the instr register, so they are stable while instr_valid=1.
- Reset values: state IDLE, pc=RESET_PC, pc_out=RESET_PC, instr=0, instr_valid=0, imem_req=0. imem_addr therefore equals RESET_PC.
- Reset asserted mid-request: imem_req drops immediately (asynchronous), and any ready/rdata arriving during reset is discarded.
- Memory protocol: imem_ready is meaningful only while imem_req=1. Ready outside REQ is ignored.

## Timing
- Reset release at edge 0: imem_req=1 after edge 1.
- imem_ready high during REQ at edge N: instr_valid=1 after edge N.
- Best-case throughput: one instruction every 2 cycles (REQ, VALID).
- Redirect latency: the first request to branch_target is issued the cycle after VALID-with-pc_src. The sequential (PC+4) word is never requested.
- stall held for K cycles in VALID extends VALID by exactly K cycles, with no change on any output.

## Structure
- Shared package (fetch_pkg):
  - state enum {IDLE, REQ, VALID};
  - field bit-position constants (COND_MSB/LSB, OP_MSB/LSB, FUNCT_MSB/LSB, RN, RD, RM, IMM24);
  - PC_STEP=4 and PC_READ_OFFSET=8.
  - The control unit uses the same field constants.
- One sub-module: instr_field_split (purely combinational, 32-bit instr in, all field outputs out).
- Everything else (FSM, PC register, instr register) lives in fetch_unit. Expected size is about 150–200 lines.

## Test plan
- Reset, then release with imem_ready=1 permanently and rdata=32'hE281_0004: first req addr 0, then instr_valid with cond=4'hE, op=0, funct=6'h28, rn=1, rd=0, rm=4, pc_plus8=8. The next request is at addr 4.
- imem_ready withheld 3 cycles in REQ: imem_req and imem_addr stay constant, instr_valid stays 0 for 3 cycles, and the word is captured on the 4th.
- In VALID with stall=1 for 5 cycles and pc_src=1 asserted throughout: outputs stay frozen. When stall drops with pc_src=1 and branch_target=32'h0000_0103, the next request is at 32'h0000_0100.
- Set pc to 32'hFFFF_FFFC via a branch, then complete a fetch with pc_src=0: the next imem_addr is 0 and pc_plus8 during VALID is 32'h0000_0004.
- Assert rst_n=0 mid-REQ and mid-VALID: imem_req and instr_valid go to 0 in the same cycle. After release, the fetch restarts at RESET_PC via IDLE.
